// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute control sequencer: walks program memory, holds the instruction register and gates decoder strobes.
// Optional single-step support is compiled in with the SEQ_SINGLE_STEP_EN macro.
module fetch_sequencer #(
    parameter int PC_WIDTH          = 8,
    parameter int PROGRAM_DataWidth = 16,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                         step,
`endif
    output logic                         prog_rd_en,
    output logic [PC_WIDTH-1:0]          prog_adr,
    input  logic [PROGRAM_DataWidth-1:0] prog_data,
    input  logic                         prog_valid,
    output logic [PROGRAM_DataWidth-1:0] instruction,
    input  logic                         dec_wr_en,
    input  logic                         dec_stat_wr_en,
    input  logic                         dec_cnt_wr_en,
    input  logic                         dec_add_offset,
    input  logic [PC_WIDTH-1:0]          dec_literal_adr,
    output logic                         reg_wr_en,
    output logic                         stat_wr_en,
    output logic [PC_WIDTH-1:0]          pc,
    output logic [1:0]                   state,
    output logic                         retired,
    output logic [CNT_WIDTH-1:0]         retired_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_FETCH   = 2'b01,
        S_DECODE  = 2'b10,
        S_EXECUTE = 2'b11
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [PC_WIDTH-1:0]          r_pc;
    logic [PC_WIDTH-1:0]          w_pc_nxt;
    logic [PROGRAM_DataWidth-1:0] r_instruction;
    logic [CNT_WIDTH-1:0]         r_retired_cnt;
    logic                         w_load_instr;
    logic                         w_rd_en;
    logic                         w_reg_wr;
    logic                         w_stat_wr;
    logic                         w_retire;
    logic                         w_start;

`ifdef SEQ_SINGLE_STEP_EN
    assign w_start = run & step;
`else
    assign w_start = run;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_load_instr = 1'b0;
        w_rd_en      = 1'b0;
        w_reg_wr     = 1'b0;
        w_stat_wr    = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start)
                    w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                w_rd_en = 1'b1;
                if (prog_valid) begin
                    w_load_instr = 1'b1;
                    w_state_nxt  = S_DECODE;
                end
            end
            S_DECODE: begin
                w_state_nxt = S_EXECUTE;
            end
            S_EXECUTE: begin
                w_reg_wr  = dec_wr_en;
                w_stat_wr = dec_stat_wr_en;
                w_retire  = 1'b1;
                // Relative jumps rely on modulo wrap of the PC-width adder.
                if (dec_cnt_wr_en && dec_add_offset)
                    w_pc_nxt = r_pc + dec_literal_adr;
                else if (dec_cnt_wr_en)
                    w_pc_nxt = dec_literal_adr;
                else
                    w_pc_nxt = r_pc + PC_WIDTH'(1);
`ifdef SEQ_SINGLE_STEP_EN
                w_state_nxt = S_IDLE;
`else
                w_state_nxt = run ? S_FETCH : S_IDLE;
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_instruction <= '0;
            r_retired_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_load_instr)
                r_instruction <= prog_data;
            if (w_retire && (r_retired_cnt != {CNT_WIDTH{1'b1}}))
                r_retired_cnt <= r_retired_cnt + CNT_WIDTH'(1);
        end
    end

    // Strobes are also gated by reset so they drop in the same instant reset rises.
    assign prog_rd_en  = w_rd_en   & ~reset;
    assign reg_wr_en   = w_reg_wr  & ~reset;
    assign stat_wr_en  = w_stat_wr & ~reset;
    assign retired     = w_retire  & ~reset;
    assign prog_adr    = r_pc;
    assign pc          = r_pc;
    assign state       = r_state;
    assign instruction = r_instruction;
    assign retired_cnt = r_retired_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: instruction flow, PC update modes, stalls, run drop and reset.
// Builds against the default configuration, or the single-step one when SEQ_SINGLE_STEP_EN is defined.
module tb_fetch_sequencer;

    localparam logic [1:0] S_IDLE = 2'b00, S_FETCH = 2'b01, S_DECODE = 2'b10, S_EXECUTE = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
`ifdef SEQ_SINGLE_STEP_EN
    logic        step;
`endif
    logic        prog_rd_en;
    logic [7:0]  prog_adr;
    logic [15:0] prog_data;
    logic        prog_valid;
    logic [15:0] instruction;
    logic        dec_wr_en, dec_stat_wr_en, dec_cnt_wr_en, dec_add_offset;
    logic [7:0]  dec_literal_adr;
    logic        reg_wr_en, stat_wr_en;
    logic [7:0]  pc;
    logic [1:0]  state;
    logic        retired;
    logic [15:0] retired_cnt;

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt = 0;

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .run(run),
`ifdef SEQ_SINGLE_STEP_EN
        .step(step),
`endif
        .prog_rd_en(prog_rd_en), .prog_adr(prog_adr), .prog_data(prog_data),
        .prog_valid(prog_valid), .instruction(instruction),
        .dec_wr_en(dec_wr_en), .dec_stat_wr_en(dec_stat_wr_en),
        .dec_cnt_wr_en(dec_cnt_wr_en), .dec_add_offset(dec_add_offset),
        .dec_literal_adr(dec_literal_adr),
        .reg_wr_en(reg_wr_en), .stat_wr_en(stat_wr_en), .pc(pc), .state(state),
        .retired(retired), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered with the FSM in FETCH and prog_valid=1; leaves one cycle after EXECUTE.
    task automatic exec_instr(input logic [15:0] data, input logic wr, input logic st,
                              input logic cnt, input logic add, input logic [7:0] lit,
                              input logic [1:0] st_after);
        prog_data       = data;
        dec_wr_en       = wr;
        dec_stat_wr_en  = st;
        dec_cnt_wr_en   = cnt;
        dec_add_offset  = add;
        dec_literal_adr = lit;
        tick();
        chk("decode_state", 32'(state), 32'(S_DECODE));
        chk("decode_instr", 32'(instruction), 32'(data));
        chk("decode_strobes", {29'd0, reg_wr_en, stat_wr_en, prog_rd_en}, 32'd0);
        tick();
        chk("exec_state", 32'(state), 32'(S_EXECUTE));
        chk("exec_strobes", {29'd0, reg_wr_en, stat_wr_en, retired}, {29'd0, wr, st, 1'b1});
        exp_cnt++;
        tick();
        chk("post_state", 32'(state), 32'(st_after));
        chk("post_strobes", {30'd0, reg_wr_en, retired}, 32'd0);
        chk("post_cnt", 32'(retired_cnt), 32'(exp_cnt));
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; prog_data = '0; prog_valid = 1'b0;
        dec_wr_en = 1'b0; dec_stat_wr_en = 1'b0; dec_cnt_wr_en = 1'b0;
        dec_add_offset = 1'b0; dec_literal_adr = '0;
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b0;
`endif
        #2;
        chk("rst_state", 32'(state), 32'(S_IDLE));
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_instr", 32'(instruction), 32'd0);
        chk("rst_cnt", 32'(retired_cnt), 32'd0);
        chk("rst_strobes", {28'd0, prog_rd_en, reg_wr_en, stat_wr_en, retired}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        run = 1'b1;
        prog_valid = 1'b1;

`ifdef SEQ_SINGLE_STEP_EN
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++) begin
                tick();
                chk("ss_wait_idle", 32'(state), 32'(S_IDLE));
            end
            step = 1'b1;
            tick();
            chk("ss_fetch", 32'(state), 32'(S_FETCH));
            step = 1'b0;
            exec_instr(16'h1012, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, S_IDLE);
            chk("ss_pc", 32'(pc), 32'(k + 1));
        end
        tick();
        chk("ss_hold_idle", 32'(state), 32'(S_IDLE));
        chk("ss_cnt_hold", 32'(retired_cnt), 32'd2);
`else
        chk("pre_idle", 32'(state), 32'(S_IDLE));
        tick();
        chk("fetch_state", 32'(state), 32'(S_FETCH));
        chk("fetch_rd_en", 32'(prog_rd_en), 32'd1);
        chk("fetch_adr", 32'(prog_adr), 32'd0);

        // ADD r1,r2: both strobes, pc 0->1
        exec_instr(16'h1012, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, S_FETCH);
        chk("add_pc", 32'(pc), 32'h01);

        exec_instr(16'h3010, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10, S_FETCH);
        chk("goto10_pc", 32'(pc), 32'h10);
        exec_instr(16'h303F, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3F, S_FETCH);
        chk("goto3f_pc", 32'(pc), 32'h3F);

        exec_instr(16'h3020, 1'b0, 1'b0, 1'b1, 1'b0, 8'h20, S_FETCH);
        exec_instr(16'h40FE, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFE, S_FETCH);
        chk("ifz_taken_pc", 32'(pc), 32'h1E);
        exec_instr(16'h3020, 1'b0, 1'b0, 1'b1, 1'b0, 8'h20, S_FETCH);
        exec_instr(16'h40FE, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFE, S_FETCH);
        chk("ifz_not_taken_pc", 32'(pc), 32'h21);

        exec_instr(16'h30FF, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, S_FETCH);
        chk("goto_ff_pc", 32'(pc), 32'hFF);
        exec_instr(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, S_FETCH);
        chk("nop_wrap_pc", 32'(pc), 32'h00);

        // Memory stall: FSM must sit in FETCH with no strobes
        prog_valid = 1'b0;
        dec_wr_en = 1'b1; dec_stat_wr_en = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("stall_state", 32'(state), 32'(S_FETCH));
            chk("stall_strobes", {29'd0, reg_wr_en, stat_wr_en, prog_rd_en}, 32'd1);
        end
        prog_valid = 1'b1;

        // run dropped in DECODE: instruction completes, then IDLE
        prog_data = 16'h0000; dec_wr_en = 1'b1; dec_stat_wr_en = 1'b0; dec_cnt_wr_en = 1'b0;
        tick();
        chk("drop_decode", 32'(state), 32'(S_DECODE));
        run = 1'b0;
        tick();
        chk("drop_exec", {29'd0, state, retired}, {29'd0, S_EXECUTE, 1'b1});
        chk("drop_exec_wr", 32'(reg_wr_en), 32'd1);
        exp_cnt++;
        tick();
        chk("drop_idle", 32'(state), 32'(S_IDLE));
        chk("drop_pc", 32'(pc), 32'h01);
        tick();
        chk("drop_stay_idle", {30'd0, state}, 32'(S_IDLE));
        chk("idle_rd_en", 32'(prog_rd_en), 32'd0);
        chk("drop_cnt", 32'(retired_cnt), 32'(exp_cnt));

        // Reset in EXECUTE: strobes vanish and pc clears without a clock edge
        run = 1'b1;
        tick();
        chk("rr_fetch", 32'(state), 32'(S_FETCH));
        prog_data = 16'h1055; dec_wr_en = 1'b1; dec_stat_wr_en = 1'b1;
        dec_cnt_wr_en = 1'b1; dec_add_offset = 1'b0; dec_literal_adr = 8'h55;
        tick();
        tick();
        chk("rr_exec", {29'd0, state, reg_wr_en}, {29'd0, S_EXECUTE, 1'b1});
        #2;
        reset = 1'b1;
        #1;
        chk("rr_strobes", {28'd0, reg_wr_en, stat_wr_en, retired, prog_rd_en}, 32'd0);
        chk("rr_state", 32'(state), 32'(S_IDLE));
        chk("rr_pc", 32'(pc), 32'd0);
        chk("rr_instr", 32'(instruction), 32'd0);
        chk("rr_cnt", 32'(retired_cnt), 32'd0);
        tick();
        chk("rr_pc_held", 32'(pc), 32'd0);
        reset = 1'b0;
        run = 1'b0;
        tick();
        chk("rr_after_idle", 32'(state), 32'(S_IDLE));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
